// File: rtl/spidergon_traffic_gen.sv
// spidergon_traffic_gen: LFSR-driven wormhole packet injector for one Spidergon node's local port
module spidergon_traffic_gen #(
    parameter int          NUM_OF_NODES            = 8,
    parameter int          FLIT_DATA_WIDTH         = 16,
    parameter int          NUM_OF_VIRTUAL_CHANNELS = 2,
    parameter int          NODE_ID                 = 0,
    parameter int          PACKET_LENGTH           = 4,
    parameter int          INJECTION_GAP           = 3,
    parameter logic [15:0] LFSR_SEED               = 16'hACE1,
    localparam int         ID_W = $clog2(NUM_OF_NODES),
    localparam int         VC_W = (NUM_OF_VIRTUAL_CHANNELS > 1) ? $clog2(NUM_OF_VIRTUAL_CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       flit_ready,
    output logic                       flit_valid,
    output logic [FLIT_DATA_WIDTH-1:0] flit_out,
    output logic [1:0]                 flit_type,
    output logic [VC_W-1:0]            flit_vc,
    output logic [15:0]                packets_sent,
    output logic                       busy
);
    typedef enum logic [2:0] {IDLE, HEAD, BODY, TAIL, GAP} state_t;
    state_t                     state_q, state_d;
    logic [15:0]                lfsr_q, lfsr_d, cnt_q, cnt_d, pkts_q, pkts_d;
    logic [ID_W-1:0]            dest_q, dest_d, raw_dest;
    logic [VC_W-1:0]            vc_q, vc_d;
    logic                       valid_q, valid_d, busy_q, busy_d;
    logic [FLIT_DATA_WIDTH-1:0] data_q, data_d, head_word;
    logic [1:0]                 type_q, type_d;
    logic                       fire, start;
    assign fire     = valid_q & flit_ready;
    assign raw_dest = lfsr_d[ID_W-1:0];
    always_comb begin
        lfsr_d  = fire ? ((lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000)) : lfsr_q;
        pkts_d  = pkts_q + {15'd0, fire && state_q == TAIL};
        state_d = state_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        case (state_q)
            IDLE: start = enable;
            HEAD: if (fire) begin
                state_d = (PACKET_LENGTH > 2) ? BODY : TAIL;
                cnt_d   = '0;
            end
            BODY: if (fire) begin
                state_d = (cnt_q == 16'(PACKET_LENGTH - 3)) ? TAIL : BODY;
                cnt_d   = cnt_q + 16'd1;
            end
            TAIL: if (fire) begin
                state_d = (INJECTION_GAP > 0) ? GAP : IDLE;
                start   = (INJECTION_GAP == 0) && enable;
                cnt_d   = '0;
            end
            GAP: begin
                state_d = (cnt_q == 16'(INJECTION_GAP - 1)) ? IDLE : GAP;
                start   = (cnt_q == 16'(INJECTION_GAP - 1)) && enable;
                cnt_d   = cnt_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
        // Every packet start latches a fresh destination and VC from the post-transfer state
        state_d   = start ? HEAD : state_d;
        dest_d    = start ? ((raw_dest == ID_W'(NODE_ID)) ? ID_W'(NODE_ID + 1) : raw_dest) : dest_q;
        vc_d      = start ? VC_W'(pkts_d % 16'(NUM_OF_VIRTUAL_CHANNELS)) : vc_q;
        head_word = (FLIT_DATA_WIDTH'(pkts_d) << (2 * ID_W))
                  | (FLIT_DATA_WIDTH'(ID_W'(NODE_ID)) << ID_W)
                  | FLIT_DATA_WIDTH'(dest_d);
        valid_d   = state_d inside {HEAD, BODY, TAIL};
        busy_d    = state_d != IDLE;
        type_d    = (state_d == HEAD) ? 2'b01 : (state_d == TAIL) ? 2'b10 : 2'b00;
        data_d    = (state_d == HEAD) ? head_word : valid_d ? lfsr_d[FLIT_DATA_WIDTH-1:0] : '0;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            cnt_q   <= '0;
            pkts_q  <= '0;
            dest_q  <= '0;
            vc_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            type_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            pkts_q  <= pkts_d;
            dest_q  <= dest_d;
            vc_q    <= vc_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            type_q  <= type_d;
        end
    end
    assign flit_valid   = valid_q;
    assign flit_out     = data_q;
    assign flit_type    = type_q;
    assign flit_vc      = vc_q;
    assign packets_sent = pkts_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_spidergon_traffic_gen.sv
// tb_spidergon_traffic_gen: directed and randomized checks of the traffic generator against a packet-level model
module tb_spidergon_traffic_gen;
    logic clk = 1'b0, reset = 1'b1, enable = 1'b0, flit_ready = 1'b0;
    logic v0, v1, v2, c0, c1, c2, b0, b1, b2;
    logic [15:0] d0, d1, d2, p0, p1, p2;
    logic [1:0] t0, t1, t2;
    int errors = 0, checks = 0;
    logic [15:0] m_lfsr, m_pkts;
    logic [15:0] q_data[$];
    logic [1:0]  q_type[$];
    logic        q_vc[$];

    always #5 clk = ~clk;

    spidergon_traffic_gen dut0 (.clk(clk), .reset(reset), .enable(enable), .flit_ready(flit_ready),
        .flit_valid(v0), .flit_out(d0), .flit_type(t0), .flit_vc(c0), .packets_sent(p0), .busy(b0));
    spidergon_traffic_gen #(.NODE_ID(1)) dut1 (.clk(clk), .reset(reset), .enable(enable), .flit_ready(flit_ready),
        .flit_valid(v1), .flit_out(d1), .flit_type(t1), .flit_vc(c1), .packets_sent(p1), .busy(b1));
    spidergon_traffic_gen #(.PACKET_LENGTH(2), .INJECTION_GAP(0)) dut2 (.clk(clk), .reset(reset), .enable(enable),
        .flit_ready(flit_ready), .flit_valid(v2), .flit_out(d2), .flit_type(t2), .flit_vc(c2), .packets_sent(p2), .busy(b2));

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // One whole packet: head word, then one payload per transfer, then one more advance after the tail
    task automatic gen_packet(input int node, input int plen);
        int dest;
        dest = int'(m_lfsr % 16'd8);
        if (dest == node) dest = (node + 1) % 8;
        q_data.push_back(16'((int'(m_pkts) << 6) | (node << 3) | dest));
        q_type.push_back(2'b01);
        q_vc.push_back(1'(m_pkts % 16'd2));
        for (int i = 1; i < plen; i++) begin
            m_lfsr = lfsr_step(m_lfsr);
            q_data.push_back(m_lfsr);
            q_type.push_back(i == plen - 1 ? 2'b10 : 2'b00);
            q_vc.push_back(1'(m_pkts % 16'd2));
        end
        m_lfsr = lfsr_step(m_lfsr);
        m_pkts = m_pkts + 16'd1;
    endtask

    task automatic model_init(input int node, input int plen, input int npkts);
        q_data.delete();
        q_type.delete();
        q_vc.delete();
        m_lfsr = 16'hACE1;
        m_pkts = 16'd0;
        repeat (npkts) gen_packet(node, plen);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        enable = 1'b0;
        flit_ready = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({v0, t0, d0} !== 19'd0) begin errors++; $display("FAIL reset_flit: got v=%b t=%b d=%h, expected 0 00 0000", v0, t0, d0); end
        checks++;
        if ({c0, p0, b0} !== 18'd0) begin errors++; $display("FAIL reset_status: got vc=%b ps=%0d busy=%b, expected 0 0 0", c0, p0, b0); end
        checks++;
        if ({v1, d1, t1, c1, p1, b1, v2, d2, t2, c2, p2, b2} !== 74'd0) begin
            errors++; $display("FAIL reset_others: got v1=%b ps1=%0d b1=%b v2=%b ps2=%0d b2=%b, expected all 0", v1, p1, b1, v2, p2, b2);
        end
    endtask

    task automatic test_defaults;
        do_reset();
        enable = 1'b1;
        flit_ready = 1'b1;
        tick();
        checks++;
        if (!(v0 === 1'b1 && d0 === 16'h0001 && t0 === 2'b01 && c0 === 1'b0)) begin
            errors++; $display("FAIL head0: got v=%b d=%h t=%b vc=%b, expected 1 0001 01 0", v0, d0, t0, c0);
        end
        tick();
        checks++;
        if (!(v0 === 1'b1 && d0 === 16'hE270 && t0 === 2'b00)) begin errors++; $display("FAIL body1: got v=%b d=%h t=%b, expected 1 e270 00", v0, d0, t0); end
        tick();
        checks++;
        if (!(v0 === 1'b1 && d0 === 16'h7138 && t0 === 2'b00)) begin errors++; $display("FAIL body2: got v=%b d=%h t=%b, expected 1 7138 00", v0, d0, t0); end
        tick();
        checks++;
        if (!(v0 === 1'b1 && d0 === 16'h389C && t0 === 2'b10)) begin errors++; $display("FAIL tail: got v=%b d=%h t=%b, expected 1 389c 10", v0, d0, t0); end
        tick();
        checks++;
        if (p0 !== 16'd1) begin errors++; $display("FAIL pkt_count1: got %0d, expected 1", p0); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (v0 !== 1'b0) begin errors++; $display("FAIL gap%0d: got valid=%b, expected 0", i, v0); end
            tick();
        end
        checks++;
        if (!(v0 === 1'b1 && d0 === 16'h0046 && t0 === 2'b01 && c0 === 1'b1)) begin
            errors++; $display("FAIL head1: got v=%b d=%h t=%b vc=%b, expected 1 0046 01 1", v0, d0, t0, c0);
        end
    endtask

    task automatic test_node_id;
        do_reset();
        enable = 1'b1;
        flit_ready = 1'b1;
        tick();
        checks++;
        if (!(v1 === 1'b1 && d1 === 16'h000A && t1 === 2'b01 && c1 === 1'b0)) begin
            errors++; $display("FAIL node1_head: got v=%b d=%h t=%b vc=%b, expected 1 000a 01 0", v1, d1, t1, c1);
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        enable = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (!(v0 === 1'b1 && d0 === 16'h0001 && t0 === 2'b01 && c0 === 1'b0)) begin
                errors++; $display("FAIL bp_head%0d: got v=%b d=%h t=%b vc=%b, expected 1 0001 01 0", i, v0, d0, t0, c0);
            end
            if (i < 5) tick();
        end
        flit_ready = 1'b1;
        tick();
        flit_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (!(v0 === 1'b1 && d0 === 16'hE270 && t0 === 2'b00)) begin
                errors++; $display("FAIL bp_body%0d: got v=%b d=%h t=%b, expected 1 e270 00", i, v0, d0, t0);
            end
            if (i < 3) tick();
        end
        flit_ready = 1'b1;
        tick();
        checks++;
        if (!(v0 === 1'b1 && d0 === 16'h7138)) begin errors++; $display("FAIL bp_body2: got v=%b d=%h, expected 1 7138", v0, d0); end
    endtask

    task automatic test_enable_drop;
        do_reset();
        enable = 1'b1;
        flit_ready = 1'b1;
        tick();
        tick();
        enable = 1'b0;
        tick();
        tick();
        checks++;
        if (!(v0 === 1'b1 && d0 === 16'h389C && t0 === 2'b10)) begin errors++; $display("FAIL ed_tail: got v=%b d=%h t=%b, expected 1 389c 10", v0, d0, t0); end
        tick();
        checks++;
        if (!(v0 === 1'b0 && b0 === 1'b1 && p0 === 16'd1)) begin errors++; $display("FAIL ed_gap: got v=%b busy=%b ps=%0d, expected 0 1 1", v0, b0, p0); end
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (!(v0 === 1'b0 && b0 === 1'b0)) begin errors++; $display("FAIL ed_idle%0d: got v=%b busy=%b, expected 0 0", i, v0, b0); end
        end
    endtask

    task automatic test_reset_mid;
        int n;
        do_reset();
        enable = 1'b1;
        flit_ready = 1'b1;
        n = 0;
        while (!(p0 === 16'd1 && v0 === 1'b1 && t0 === 2'b00) && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 50) begin errors++; $display("FAIL rm_timeout: got no body of packet 2 in 50 cycles, expected one"); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (!(v0 === 1'b0 && p0 === 16'd0 && b0 === 1'b0)) begin errors++; $display("FAIL rm_cleared: got v=%b ps=%0d busy=%b, expected 0 0 0", v0, p0, b0); end
        tick();
        checks++;
        if (!(v0 === 1'b1 && d0 === 16'h0001 && t0 === 2'b01 && c0 === 1'b0)) begin
            errors++; $display("FAIL rm_head: got v=%b d=%h t=%b vc=%b, expected 1 0001 01 0", v0, d0, t0, c0);
        end
    endtask

    task automatic test_back_to_back;
        model_init(0, 2, 4);
        do_reset();
        enable = 1'b1;
        flit_ready = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (!(v2 === 1'b1 && d2 === q_data[0] && t2 === q_type[0] && c2 === q_vc[0])) begin
                errors++; $display("FAIL b2b_flit%0d: got v=%b d=%h t=%b vc=%b, expected 1 %h %b %b", i, v2, d2, t2, c2, q_data[0], q_type[0], q_vc[0]);
            end
            if (i % 2 == 0) begin
                checks++;
                if (p2 !== 16'(i / 2)) begin errors++; $display("FAIL b2b_count%0d: got %0d, expected %0d", i, p2, i / 2); end
            end
            void'(q_data.pop_front());
            void'(q_type.pop_front());
            void'(q_vc.pop_front());
            tick();
        end
    endtask

    task automatic test_random;
        int done, cyc, idle;
        logic pv, pr, pc, tail_seen, after_tail;
        logic [15:0] pd, exp_ps;
        logic [1:0] pt;
        model_init(0, 4, 14);
        do_reset();
        done = 0; cyc = 0; idle = 0;
        pv = 1'b0; pr = 1'b0; pc = 1'b0; pd = '0; pt = '0;
        tail_seen = 1'b0; after_tail = 1'b0; exp_ps = '0;
        while (done < 10 && cyc < 4000) begin
            if (pv && !pr) begin
                checks++;
                if (!(v0 === 1'b1 && d0 === pd && t0 === pt && c0 === pc)) begin
                    errors++; $display("FAIL rnd_hold c%0d: got v=%b d=%h t=%b vc=%b, expected 1 %h %b %b", cyc, v0, d0, t0, c0, pd, pt, pc);
                end
            end
            if (tail_seen) begin
                checks++;
                if (p0 !== exp_ps) begin errors++; $display("FAIL rnd_count c%0d: got %0d, expected %0d", cyc, p0, exp_ps); end
                tail_seen = 1'b0;
            end
            if (!v0) idle++;
            else if (after_tail) begin
                checks++;
                if (idle < 3) begin errors++; $display("FAIL rnd_gap c%0d: got %0d idle cycles, expected at least 3", cyc, idle); end
                after_tail = 1'b0;
            end
            enable = ($urandom_range(0, 3) != 0);
            flit_ready = 1'($urandom_range(0, 1));
            if (v0 && flit_ready) begin
                checks++;
                if (q_data.size() == 0) begin
                    errors++; $display("FAIL rnd_extra c%0d: got flit %h, expected none", cyc, d0);
                end else begin
                    if (!(d0 === q_data[0] && t0 === q_type[0] && c0 === q_vc[0])) begin
                        errors++; $display("FAIL rnd_flit c%0d: got d=%h t=%b vc=%b, expected %h %b %b", cyc, d0, t0, c0, q_data[0], q_type[0], q_vc[0]);
                    end
                    if (q_type[0] == 2'b10) begin
                        exp_ps = exp_ps + 16'd1;
                        tail_seen = 1'b1;
                        after_tail = 1'b1;
                        idle = 0;
                        done++;
                    end
                    void'(q_data.pop_front());
                    void'(q_type.pop_front());
                    void'(q_vc.pop_front());
                end
            end
            pv = v0; pr = flit_ready; pd = d0; pt = t0; pc = c0;
            tick();
            cyc++;
        end
        checks++;
        if (done < 10) begin errors++; $display("FAIL rnd_timeout: got %0d packets, expected 10", done); end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_node_id();
        test_backpressure();
        test_enable_drop();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000, expected finish");
        $fatal(1);
    end
endmodule

// File: doc/spidergon_traffic_gen.md
# spidergon_traffic_gen

Per-node packet injector that drives flits into the local injection port of one Spidergon NoC node. It builds wormhole packets of the form head, body…, tail, with pseudo-random destinations and payloads, and obeys a valid/ready handshake. It counts completed packets and spaces them with a programmable idle gap. One instance sits directly upstream of each node's local input port. NoC-level benches use it to load the network with traffic.

## Interface
- NUM_OF_NODES, 8, node count; power of two, ≥4
- FLIT_DATA_WIDTH, 16, flit payload width; range 8..16
- NUM_OF_VIRTUAL_CHANNELS, 2, VCs per input port
- NODE_ID, 0, this node's index; inserted as source field
- PACKET_LENGTH, 4, flits per packet including head and tail; ≥2
- INJECTION_GAP, 3, idle cycles after each tail; ≥0
- LFSR_SEED, 16'hACE1, LFSR reset value; nonzero
- Derived: ID_W = $clog2(NUM_OF_NODES); VC_W = max(1, $clog2(NUM_OF_VIRTUAL_CHANNELS))

Ports:
- clk  in  1  clock
- reset  in  1  **one clock; reset is synchronous and active-low**
- enable  in  1  permits starting new packets
- flit_ready  in  1  node accepts the flit this cycle
- flit_valid  out  1  flit presented
- flit_out  out  FLIT_DATA_WIDTH  flit data
- flit_type  out  2  01 head, 00 body, 10 tail
- flit_vc  out  VC_W  target VC
- packets_sent  out  16  completed-packet count; wraps
- busy  out  1  high in any state other than IDLE

## Operation
- Handshake: a flit transfers on any cycle where flit_valid and flit_ready are both high.
  - Once flit_valid is asserted, flit_out, flit_type and flit_vc hold stable until the transfer.
  - flit_valid never drops without a transfer.
- LFSR: 16-bit Galois, lfsr <= (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Advances exactly once per transferred flit; otherwise it holds.
- FSM states: IDLE, HEAD, BODY, TAIL, GAP.
  - IDLE: when enable=1, latch dest = lfsr[ID_W-1:0]. If dest == NODE_ID, use dest = (NODE_ID+1) mod NUM_OF_NODES. Latch vc = packets_sent mod NUM_OF_VIRTUAL_CHANNELS. Go to HEAD.
  - HEAD: flit_type=01. flit_out = {seq, NODE_ID, dest}, packed as dest in bits [ID_W-1:0], source in bits [2·ID_W-1:ID_W], and packets_sent low bits in the remaining upper bits. On transfer, go to BODY if PACKET_LENGTH>2, else TAIL.
  - BODY: flit_type=00, flit_out = lfsr[FLIT_DATA_WIDTH-1:0]. After PACKET_LENGTH-2 transfers, go to TAIL.
  - TAIL: flit_type=10, payload rule as in BODY. On transfer, increment packets_sent (16'hFFFF wraps to 0). Go to GAP if INJECTION_GAP>0; otherwise go to HEAD if enable, else IDLE, taking a fresh dest/vc latch as in IDLE.
  - GAP: stay INJECTION_GAP cycles with flit_valid=0, then go to HEAD if enable, else IDLE, with the same fresh latch.
- flit_vc stays constant for the whole packet.
- Dropping enable mid-packet never truncates the packet; it only blocks the next one.
- flit_ready is ignored whenever flit_valid=0.

## Timing
- Reset (reset=0 at a clk edge), from the next cycle onward:
  - Outputs: flit_valid=0, flit_out=0, flit_type=00, flit_vc=0, packets_sent=0, busy=0.
  - Internal: FSM in IDLE, lfsr=LFSR_SEED, all counters 0.
  - Reset mid-packet abandons the packet with no tail.
- enable sampled high in IDLE → flit_valid=1 with the head on the next cycle.
- With flit_ready held high, one flit transfers per cycle.
  - Packet occupies PACKET_LENGTH cycles, followed by INJECTION_GAP idle cycles.
  - Steady-state period: PACKET_LENGTH+INJECTION_GAP cycles.
- packets_sent updates in the cycle after the tail transfer.
- No combinational path from flit_ready to flit_valid, flit_out or flit_type; all outputs are registered.

## Test plan
- Defaults, reset released, enable=1, flit_ready=1:
  - Head 16'h0001, vc 0.
  - Bodies 16'hE270, 16'h7138; tail 16'h389C.
  - packets_sent=1, then 3 cycles with flit_valid=0.
  - Second head 16'h0046, vc 1.
- NODE_ID=1, otherwise as above:
  - First LFSR dest 1 is remapped; head = 16'h000A (dest 2, src 1).
- Backpressure: flit_ready=0 for 5 cycles while the head is valid:
  - flit_valid stays 1, flit_out holds 16'h0001, first body stays 16'hE270.
  - Bench checks output stability every cycle.
- enable dropped during the first body:
  - Packet completes through tail 16'h389C.
  - After the gap, FSM sits in IDLE, busy=0, flit_valid=0.
- reset=0 for one cycle during BODY:
  - Next cycle flit_valid=0, packets_sent=0.
  - With enable=1, the following packet again starts with head 16'h0001.
- PACKET_LENGTH=2, INJECTION_GAP=0, flit_ready=1:
  - Head/tail alternate back-to-back with no idle cycle.
  - packets_sent increments every 2 cycles; vc toggles 0,1,0.
